serial_link_cfg_responder: RTL and testbench

// - RegBus responder for the serial-link control registers: CTRL, ISOLATED, CHANNEL_ALLOC_TX/RX_CFG.
// - Is the target end of the link bring-up sequence issued over cfg_req/cfg_rsp by software or a bench.
// - Drives link clock gate, link reset and AXI isolation requests, and tracks the isolation handshake.
// - Sits in the clk_reg domain between the cfg port and the serial link datapath.

---
 rtl/serial_link_cfg_responder_pkg.sv | 54 +++++
 rtl/serial_link_cfg_responder_if.sv | 11 +
 rtl/serial_link_cfg_responder_iso_fsm.sv | 89 ++++++++
 rtl/serial_link_cfg_responder.sv | 147 ++++++++++++++
 tb/tb_serial_link_cfg_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_cfg_responder_pkg.sv
// Shared types and constants for the serial-link configuration responder.
// Contents: RegBus request/response payloads, register offsets, CTRL field
// positions and reset value, isolation FSM state encoding, byte-mask helper.
package serial_link_cfg_responder_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              valid;
    } cfg_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              error;
        logic              ready;
    } cfg_rsp_t;

    localparam logic [ADDR_W-1:0] CTRL_OFFSET     = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ISOLATED_OFFSET = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] TX_CFG_OFFSET   = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] RX_CFG_OFFSET   = 32'h0000_000C;

    localparam logic [DATA_W-1:0] CTRL_RESET = 32'h0000_0300;
    localparam logic [DATA_W-1:0] CTRL_MASK  = 32'h0000_0303;

    localparam int unsigned CTRL_CLK_ENA_BIT = 0;
    localparam int unsigned CTRL_RESET_N_BIT = 1;
    localparam int unsigned CTRL_ISO_LSB     = 8;
    localparam int unsigned ISO_FLAG_LSB     = 8;

    typedef enum logic [1:0] {
        ISO_ST    = 2'd0,
        DEISO_ST  = 2'd1,
        ACTIVE_ST = 2'd2,
        REISO_ST  = 2'd3
    } iso_state_e;

    // Expand byte strobes into a bit mask.
    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/serial_link_cfg_responder_if.sv
// RegBus configuration port: request from the master, response from the responder.
// Ports (modports): master drives req and observes rsp; slave observes req and drives rsp.
interface serial_link_cfg_responder_if;
    import serial_link_cfg_responder_pkg::*;

    cfg_req_t req;
    cfg_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/serial_link_cfg_responder_iso_fsm.sv
// Isolation handshake tracker for one AXI direction.
// Ports: clk_i/rst_ni clock and async active-low reset; iso_req_i requested
// isolation level (CTRL.iso_d); isolated_i synchronised datapath status;
// flag_clr_i read-clear of the sticky timeout flag; flag_o sticky timeout flag.
module serial_link_cfg_responder_iso_fsm
    import serial_link_cfg_responder_pkg::*;
#(
    parameter int unsigned IsoTimeout = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic iso_req_i,
    input  logic isolated_i,
    input  logic flag_clr_i,
    output logic flag_o
);

    localparam int unsigned CNT_W = $clog2(IsoTimeout + 1);

    iso_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;
    logic             transient_c;
    logic             timeout_c;
    logic             flag_set_c;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ISO_ST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; request toggles in a transient state flip to the opposite one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ISO_ST:    if (!iso_req_i) state_d = DEISO_ST;
            DEISO_ST: begin
                if (iso_req_i)                     state_d = REISO_ST;
                else if (!isolated_i || timeout_c) state_d = ACTIVE_ST;
            end
            ACTIVE_ST: if (iso_req_i) state_d = REISO_ST;
            REISO_ST: begin
                if (!iso_req_i)                   state_d = DEISO_ST;
                else if (isolated_i || timeout_c) state_d = ISO_ST;
            end
            default:   state_d = ISO_ST;
        endcase
    end

    // Outputs: timeout detect, flagged only when the ack has not arrived.
    always_comb begin
        transient_c = 1'b0;
        timeout_c   = 1'b0;
        flag_set_c  = 1'b0;
        transient_c = (state_q == DEISO_ST) || (state_q == REISO_ST);
        timeout_c   = transient_c && (cnt_q == CNT_W'(IsoTimeout - 1));
        if (state_q == DEISO_ST) begin
            flag_set_c = timeout_c && !iso_req_i && isolated_i;
        end else if (state_q == REISO_ST) begin
            flag_set_c = timeout_c && iso_req_i && !isolated_i;
        end
    end

    // Timeout counter restarts on every state change; sticky flag, set beats clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (transient_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (flag_set_c) begin
                flag_q <= 1'b1;
            end else if (flag_clr_i) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/serial_link_cfg_responder.sv
// RegBus responder for the serial-link control registers (CTRL, ISOLATED,
// CHANNEL_ALLOC_TX/RX_CFG) driving link clock gate, reset and isolation.
// Ports: clk_i/rst_ni clock and async active-low reset; cfg RegBus slave port;
// clk_ena_o clock-gate enable; link_rst_no link reset (active low);
// isolate_o isolation request [0]=AXI in [1]=AXI out; isolated_i async
// isolation status; tx/rx_alloc_cfg_o [0] bypass_en [1] auto_flush_en.
module serial_link_cfg_responder
    import serial_link_cfg_responder_pkg::*;
#(
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned RstHoldCycles = 4,
    parameter int unsigned IsoTimeout    = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    serial_link_cfg_responder_if.slave  cfg,
    output logic                        clk_ena_o,
    output logic                        link_rst_no,
    output logic [1:0]                  isolate_o,
    input  logic [1:0]                  isolated_i,
    output logic [1:0]                  tx_alloc_cfg_o,
    output logic [1:0]                  rx_alloc_cfg_o
);

    localparam int unsigned HOLD_W = $clog2(RstHoldCycles + 1);

    logic [1:0]        sync_q [SyncStages];
    logic [1:0]        iso_sync;
    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [1:0]        tx_q, tx_d, rx_q, rx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              link_rst_q;
    logic [1:0]        flags;

    logic              sel_ctrl_c, sel_iso_c, sel_tx_c, sel_rx_c;
    logic              err_c, we_c, flag_clr_c;
    logic [DATA_W-1:0] mask_c;
    logic [DATA_W-1:0] rdata_c;
    cfg_rsp_t          rsp_c;

    // Multi-flop synchroniser for the asynchronous isolation status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SyncStages; i++) begin
                sync_q[i] <= 2'b00;
            end
        end else begin
            sync_q[0] <= isolated_i;
            for (int unsigned i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign iso_sync = sync_q[SyncStages-1];

    // Address decode, access error and zero-wait-state response.
    always_comb begin
        sel_ctrl_c = cfg.req.addr == CTRL_OFFSET;
        sel_iso_c  = cfg.req.addr == ISOLATED_OFFSET;
        sel_tx_c   = cfg.req.addr == TX_CFG_OFFSET;
        sel_rx_c   = cfg.req.addr == RX_CFG_OFFSET;
        err_c      = 1'b0;
        if (cfg.req.valid) begin
            if (!(sel_ctrl_c || sel_iso_c || sel_tx_c || sel_rx_c)) begin
                err_c = 1'b1;
            end else if (cfg.req.write && (sel_tx_c || sel_rx_c) && (iso_sync != 2'b11)) begin
                // Allocator config may only change while both directions are isolated.
                err_c = 1'b1;
            end
        end
        we_c       = cfg.req.valid && cfg.req.write && !err_c;
        flag_clr_c = cfg.req.valid && !cfg.req.write && sel_iso_c;
        mask_c     = strb_mask(cfg.req.wstrb);

        rdata_c = '0;
        if (sel_ctrl_c) rdata_c = ctrl_q;
        if (sel_iso_c) begin
            rdata_c[1:0]                    = iso_sync;
            rdata_c[ISO_FLAG_LSB +: 2]      = flags;
        end
        if (sel_tx_c) rdata_c[1:0] = tx_q;
        if (sel_rx_c) rdata_c[1:0] = rx_q;
        if (err_c) rdata_c = '0;

        rsp_c.rdata = rdata_c;
        rsp_c.error = err_c;
        rsp_c.ready = cfg.req.valid;
    end

    assign cfg.rsp = rsp_c;

    // Register write merge and link reset hold counter.
    always_comb begin
        ctrl_d = ctrl_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        hold_d = hold_q;
        if (we_c && sel_ctrl_c) begin
            ctrl_d = ((ctrl_q & ~mask_c) | (cfg.req.wdata & mask_c)) & CTRL_MASK;
        end
        if (we_c && sel_tx_c && cfg.req.wstrb[0]) tx_d = cfg.req.wdata[1:0];
        if (we_c && sel_rx_c && cfg.req.wstrb[0]) rx_d = cfg.req.wdata[1:0];
        if (ctrl_q[CTRL_RESET_N_BIT] && !ctrl_d[CTRL_RESET_N_BIT]) begin
            hold_d = HOLD_W'(RstHoldCycles);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q     <= CTRL_RESET;
            tx_q       <= 2'b00;
            rx_q       <= 2'b00;
            hold_q     <= HOLD_W'(RstHoldCycles);
            link_rst_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            hold_q     <= hold_d;
            link_rst_q <= ctrl_d[CTRL_RESET_N_BIT] && (hold_d == '0);
        end
    end

    // One isolation tracker per direction: [0] AXI in, [1] AXI out.
    for (genvar d = 0; d < 2; d++) begin : g_iso
        serial_link_cfg_responder_iso_fsm #(
            .IsoTimeout (IsoTimeout)
        ) i_iso_fsm (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .iso_req_i  (ctrl_q[CTRL_ISO_LSB + d]),
            .isolated_i (iso_sync[d]),
            .flag_clr_i (flag_clr_c),
            .flag_o     (flags[d])
        );
    end

    assign clk_ena_o      = ctrl_q[CTRL_CLK_ENA_BIT];
    assign link_rst_no    = link_rst_q;
    assign isolate_o      = ctrl_q[CTRL_ISO_LSB +: 2];
    assign tx_alloc_cfg_o = tx_q;
    assign rx_alloc_cfg_o = rx_q;

endmodule

// File: tb/tb_serial_link_cfg_responder.sv
// Directed bench for serial_link_cfg_responder: register access, link reset
// hold, isolation handshake, timeouts, access errors and async reset.
module tb_serial_link_cfg_responder;
    import serial_link_cfg_responder_pkg::*;

    localparam int unsigned ISO_TO = 64;

    logic       clk;
    logic       rst_ni;
    logic       clk_ena;
    logic       link_rst_n;
    logic [1:0] isolate;
    logic [1:0] isolated;
    logic [1:0] tx_cfg;
    logic [1:0] rx_cfg;

    int checks;
    int errors;

    serial_link_cfg_responder_if cfg_if ();

    serial_link_cfg_responder #(
        .SyncStages    (2),
        .RstHoldCycles (4),
        .IsoTimeout    (ISO_TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .cfg            (cfg_if),
        .clk_ena_o      (clk_ena),
        .link_rst_no    (link_rst_n),
        .isolate_o      (isolate),
        .isolated_i     (isolated),
        .tx_alloc_cfg_o (tx_cfg),
        .rx_alloc_cfg_o (rx_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One RegBus transfer; response sampled mid-cycle, returns #1 after the edge.
    task automatic bus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output logic err, output logic rdy);
        @(negedge clk);
        cfg_if.req.addr  = addr;
        cfg_if.req.write = wr;
        cfg_if.req.wdata = wdata;
        cfg_if.req.wstrb = strb;
        cfg_if.req.valid = 1'b1;
        #1;
        rdata = cfg_if.rsp.rdata;
        err   = cfg_if.rsp.error;
        rdy   = cfg_if.rsp.ready;
        @(posedge clk);
        #1;
        cfg_if.req.valid = 1'b0;
        cfg_if.req.write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er, rdy;
        #1;
        checks++; if (clk_ena !== 1'b0) begin errors++; $display("FAIL rst_clk_ena got %b exp 0", clk_ena); end
        checks++; if (link_rst_n !== 1'b0) begin errors++; $display("FAIL rst_link_rst got %b exp 0", link_rst_n); end
        checks++; if (isolate !== 2'b11) begin errors++; $display("FAIL rst_isolate got %b exp 11", isolate); end
        checks++; if ({tx_cfg, rx_cfg} !== 4'b0000) begin errors++; $display("FAIL rst_alloc got %b exp 0000", {tx_cfg, rx_cfg}); end
        checks++; if (cfg_if.rsp.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", cfg_if.rsp.ready); end
        @(negedge clk);
        rst_ni = 1'b1;
        bus(32'h0, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h300) begin errors++; $display("FAIL ctrl_reset_val got %h exp 00000300", rd); end
        checks++; if (rdy !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL ctrl_read_rsp got rdy=%b err=%b exp 1 0", rdy, er); end
    endtask

    task automatic test_isolated_sync();
        logic [31:0] rd;
        logic        er, rdy;
        cycles(3);
        bus(32'h4, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL isolated_sync got %h exp 00000003", rd); end
    endtask

    task automatic test_link_reset();
        logic [31:0] rd;
        logic        er, rdy;
        // Hold expired long ago: reset release is immediate.
        bus(32'h0, 1'b1, 32'h302, 4'hF, rd, er, rdy);
        checks++; if (link_rst_n !== 1'b1) begin errors++; $display("FAIL rst_release_idle got %b exp 1", link_rst_n); end
        // Falling reset_n reloads the hold counter.
        bus(32'h0, 1'b1, 32'h300, 4'hF, rd, er, rdy);
        checks++; if (link_rst_n !== 1'b0) begin errors++; $display("FAIL rst_assert got %b exp 0", link_rst_n); end
        bus(32'h0, 1'b1, 32'h303, 4'hF, rd, er, rdy);
        checks++; if (clk_ena !== 1'b1) begin errors++; $display("FAIL clk_ena_set got %b exp 1", clk_ena); end
        checks++; if (link_rst_n !== 1'b0) begin errors++; $display("FAIL rst_hold_1 got %b exp 0", link_rst_n); end
        cycles(1);
        checks++; if (link_rst_n !== 1'b0) begin errors++; $display("FAIL rst_hold_2 got %b exp 0", link_rst_n); end
        cycles(1);
        checks++; if (link_rst_n !== 1'b0) begin errors++; $display("FAIL rst_hold_3 got %b exp 0", link_rst_n); end
        cycles(1);
        checks++; if (link_rst_n !== 1'b1) begin errors++; $display("FAIL rst_hold_done got %b exp 1", link_rst_n); end
    endtask

    task automatic test_alloc_isolated();
        logic [31:0] rd;
        logic        er, rdy;
        bus(32'h8, 1'b1, 32'h3, 4'hF, rd, er, rdy);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL tx_alloc_err got %b exp 0", er); end
        checks++; if (tx_cfg !== 2'b11) begin errors++; $display("FAIL tx_alloc_val got %b exp 11", tx_cfg); end
        bus(32'h8, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL tx_alloc_read got %h exp 00000003", rd); end
    endtask

    task automatic test_deisolate();
        logic [31:0] rd;
        logic        er, rdy;
        bit          done;
        bus(32'h0, 1'b1, 32'h003, 4'hF, rd, er, rdy);
        checks++; if (isolate !== 2'b00) begin errors++; $display("FAIL deiso_req got %b exp 00", isolate); end
        cycles(10);
        isolated = 2'b00;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            bus(32'h4, 1'b0, 32'h0, 4'h0, rd, er, rdy);
            if (rd === 32'h0) done = 1'b1;
        end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL deiso_poll got %h exp 00000000", rd); end
        cycles(2);
        bus(32'hC, 1'b1, 32'h1, 4'hF, rd, er, rdy);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rx_alloc_active_err got %b exp 1", er); end
        checks++; if (rx_cfg !== 2'b00) begin errors++; $display("FAIL rx_alloc_dropped got %b exp 00", rx_cfg); end
        checks++; if (tx_cfg !== 2'b11) begin errors++; $display("FAIL tx_alloc_kept got %b exp 11", tx_cfg); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic        er, rdy;
        bus(32'h0, 1'b1, 32'h303, 4'hF, rd, er, rdy);
        cycles(3);
        isolated = 2'b11;
        cycles(5);
        bus(32'h4, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL reiso_no_flag got %h exp 00000003", rd); end
        bus(32'h0, 1'b1, 32'h003, 4'hF, rd, er, rdy);
        cycles(ISO_TO + 10);
        bus(32'h4, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h303) begin errors++; $display("FAIL timeout_flags got %h exp 00000303", rd); end
        bus(32'h4, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h003) begin errors++; $display("FAIL timeout_clear got %h exp 00000003", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er, rdy;
        bus(32'h10, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (er !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL unmapped_read got err=%b rdy=%b exp 1 1", er, rdy); end
        bus(32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, rdy);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped_write got %b exp 1", er); end
        bus(32'h2, 1'b1, 32'h0, 4'hF, rd, er, rdy);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_write got %b exp 1", er); end
        bus(32'h0, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h003) begin errors++; $display("FAIL ctrl_unchanged got %h exp 00000003", rd); end
        checks++; if (clk_ena !== 1'b1 || isolate !== 2'b00) begin errors++; $display("FAIL outputs_unchanged got clk=%b iso=%b exp 1 00", clk_ena, isolate); end
        // Byte-1-only write sets iso bits, leaves byte 0 alone.
        bus(32'h0, 1'b1, 32'h0000_0300, 4'b0010, rd, er, rdy);
        bus(32'h0, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h303) begin errors++; $display("FAIL byte_write got %h exp 00000303", rd); end
        checks++; if (isolate !== 2'b11) begin errors++; $display("FAIL byte_write_iso got %b exp 11", isolate); end
    endtask

    task automatic test_reset_mid_deiso();
        logic [31:0] rd;
        logic        er, rdy;
        cycles(5);
        bus(32'h0, 1'b1, 32'h003, 4'hF, rd, er, rdy);
        cycles(3);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (isolate !== 2'b11) begin errors++; $display("FAIL midrst_isolate got %b exp 11", isolate); end
        checks++; if (clk_ena !== 1'b0 || link_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_clk_rst got clk=%b rst=%b exp 0 0", clk_ena, link_rst_n); end
        checks++; if ({tx_cfg, rx_cfg} !== 4'b0000) begin errors++; $display("FAIL midrst_alloc got %b exp 0000", {tx_cfg, rx_cfg}); end
        cycles(2);
        @(negedge clk);
        rst_ni = 1'b1;
        cycles(ISO_TO + 5);
        bus(32'h0, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h300) begin errors++; $display("FAIL midrst_ctrl got %h exp 00000300", rd); end
        bus(32'h4, 1'b0, 32'h0, 4'h0, rd, er, rdy);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL midrst_isolated got %h exp 00000003", rd); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_ni           = 1'b0;
        isolated         = 2'b11;
        cfg_if.req.addr  = '0;
        cfg_if.req.write = 1'b0;
        cfg_if.req.wdata = '0;
        cfg_if.req.wstrb = '0;
        cfg_if.req.valid = 1'b0;
        cycles(2);
        test_reset();
        test_isolated_sync();
        test_link_reset();
        test_alloc_isolated();
        test_deisolate();
        test_timeout();
        test_errors();
        test_reset_mid_deiso();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
